// File: rtl/hilo_mdu_ctrl_if.sv
// HI/LO sequencer bus: EX-stage request side plus stall/done/HI/LO results.
interface hilo_mdu_ctrl_if;
  logic        start;
  logic [7:0]  op;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side drives the request, sees stall and results
  modport master (
    output start, op, num1, num2, flush,
    input  stall, done, hi, lo
  );

  // Sequencer side
  modport slave (
    input  start, op, num1, num2, flush,
    output stall, done, hi, lo
  );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Radix-2 restoring divider (32 iterations) and a registered multiplier
// held for MUL_LAT cycles; stalls the pipeline while busy, aborts on flush.
module hilo_mdu_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input logic           i_clk,
  input logic           i_rst,
  hilo_mdu_ctrl_if.slave bus
);

  localparam logic [7:0] LP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] LP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] LP_MULT  = 8'b0001_1000;
  localparam logic [7:0] LP_MULTU = 8'b0001_1001;
  localparam logic [7:0] LP_DIV   = 8'b0001_1010;
  localparam logic [7:0] LP_DIVU  = 8'b0001_1011;

  localparam logic [4:0] LP_MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] LP_DIV_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_rem;     // remainder / product high word
  logic [31:0] r_quo;     // quotient / multiplicand / product low word
  logic [31:0] r_dvs;     // divisor / multiplier magnitude
  logic        r_qsign;   // quotient sign (DIV) or product sign (MULT)
  logic        r_rsign;   // remainder sign (DIV)
  logic [4:0]  r_cnt;

  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_div0;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [32:0] w_diff;
  logic [63:0] w_prod_mag;
  logic [63:0] w_prod;
  logic        w_stall;
  logic        w_done;

  assign w_accept = bus.start & ~bus.flush;
  assign w_is_mul = (bus.op == LP_MULT) | (bus.op == LP_MULTU);
  assign w_is_div = (bus.op == LP_DIV)  | (bus.op == LP_DIVU);
  assign w_signed = (bus.op == LP_MULT) | (bus.op == LP_DIV);
  assign w_div0   = (bus.num2 == '0);

  assign w_abs1 = (w_signed & bus.num1[31]) ? (~bus.num1 + 32'd1) : bus.num1;
  assign w_abs2 = (w_signed & bus.num2[31]) ? (~bus.num2 + 32'd1) : bus.num2;

  // The shifted partial remainder can reach 33 bits, so the trial subtract
  // is done one bit wider than the divisor.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift - {1'b0, r_dvs};

  assign w_prod_mag = {32'd0, r_quo} * {32'd0, r_dvs};
  assign w_prod     = r_qsign ? (~w_prod_mag + 64'd1) : w_prod_mag;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, stall and done decode
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept & w_is_mul) begin
          w_next  = S_MUL;
          w_stall = 1'b1;
        end else if (w_accept & w_is_div) begin
          w_next  = w_div0 ? S_FIN : S_DIV;
          w_stall = 1'b1;
        end
      end
      S_MUL: begin
        w_stall = 1'b1;
        if (r_cnt == LP_MUL_LAST) w_next = S_FIN;
      end
      S_DIV: begin
        w_stall = 1'b1;
        if (r_cnt == LP_DIV_LAST) w_next = S_FIN;
      end
      S_FIN: begin
        w_done = ~bus.flush;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  // Operand capture, divide iterations, product capture and HI/LO commit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.start) begin
            if (bus.op == LP_MTHI) r_hi <= bus.num1;
            if (bus.op == LP_MTLO) r_lo <= bus.num1;
            if (w_is_mul) begin
              r_quo   <= w_abs1;
              r_dvs   <= w_abs2;
              r_qsign <= w_signed & (bus.num1[31] ^ bus.num2[31]);
              r_rsign <= 1'b0;
            end
            if (w_is_div) begin
              if (w_div0) begin
                // Divide by zero skips iteration; result is staged for FIN.
                r_quo   <= '1;
                r_rem   <= bus.num1;
                r_qsign <= 1'b0;
                r_rsign <= 1'b0;
              end else begin
                r_rem   <= '0;
                r_quo   <= w_abs1;
                r_dvs   <= w_abs2;
                r_qsign <= w_signed & (bus.num1[31] ^ bus.num2[31]);
                r_rsign <= w_signed & bus.num1[31];
              end
            end
          end
        end
        S_MUL: begin
          if (r_cnt == LP_MUL_LAST) begin
            // Product already signed here, so commit must not re-apply sign.
            {r_rem, r_quo} <= w_prod;
            r_qsign        <= 1'b0;
            r_rsign        <= 1'b0;
            r_cnt          <= '0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DIV: begin
          if (w_ge) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_cnt <= (r_cnt == LP_DIV_LAST) ? 5'd0 : (r_cnt + 5'd1);
        end
        S_FIN: begin
          r_hi  <= r_rsign ? (~r_rem + 32'd1) : r_rem;
          r_lo  <= r_qsign ? (~r_quo + 32'd1) : r_quo;
          r_cnt <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.stall = w_stall;
  assign bus.done  = w_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: table of MULT/DIV vectors plus
// hand-written MTHI/MTLO, flush, reset and ignored-op sequences.
module tb_hilo_mdu_ctrl;

  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  vec_t vecs[12];

  hilo_mdu_ctrl_if bus ();

  hilo_mdu_ctrl #(.MUL_LAT(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op with start held until done, then let it leave EX.
  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
    int stall_cnt;
    int done_cyc;
    stall_cnt = 0;
    done_cyc  = -1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.num1  = a;
    bus.num2  = b;
    bus.flush = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      #1;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.stall) stall_cnt++;
      tick();
      if (cyc == 0) begin
        bus.num1 = $urandom;
        bus.num2 = $urandom;
      end
    end
    chk({name, " done_cycle"}, 64'(done_cyc), 64'(lat));
    chk({name, " stall_cycles"}, 64'(stall_cnt), 64'(lat));
    tick();
    bus.start = 1'b0;
    bus.op    = '0;
    #1;
    if (done_cyc >= 0) begin
      m_hi = ehi;
      m_lo = elo;
    end
    chk({name, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, " lo"}, 64'(bus.lo), 64'(elo));
    chk({name, " no_restart"}, {62'd0, bus.stall, bus.done}, 64'd0);
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.num1  = '0;
    bus.num2  = '0;
    bus.flush = 1'b0;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 2};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 2};
    vecs[2]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 2};
    vecs[3]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2};
    vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
    vecs[6]  = '{OP_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
    vecs[8]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33};
    vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
    vecs[10] = '{OP_DIVU,  32'd0,         32'd0,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[11] = '{OP_DIVU,  32'd5,         32'hFFFF_FFFF, 32'd5,        32'd0,         33};

    // Reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset stall_done", {62'd0, bus.stall, bus.done}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    tick();

    // MTHI then MTLO back to back, no stall
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.num1  = 32'h0000_1234;
    #1;
    chk("mthi stall", {63'd0, bus.stall}, 64'd0);
    tick();
    bus.op   = OP_MTLO;
    bus.num1 = 32'h0000_ABCD;
    #1;
    chk("mtlo stall", {63'd0, bus.stall}, 64'd0);
    chk("mthi hi", 64'(bus.hi), 64'h1234);
    tick();
    bus.start = 1'b0;
    #1;
    chk("mtlo lo", 64'(bus.lo), 64'hABCD);
    chk("mthi/mtlo done", {63'd0, bus.done}, 64'd0);
    m_hi = 32'h1234;
    m_lo = 32'hABCD;
    tick();

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].lat);
    end

    // Non-HI/LO op is ignored
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.num1  = 32'h5555_5555;
    #1;
    chk("add stall", {63'd0, bus.stall}, 64'd0);
    tick();
    bus.start = 1'b0;
    #1;
    chk("add hi", 64'(bus.hi), 64'(m_hi));
    chk("add lo", 64'(bus.lo), 64'(m_lo));
    chk("add stall_done", {62'd0, bus.stall, bus.done}, 64'd0);

    // Flush with start in IDLE: DIV not accepted, MTHI not written
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_DIV;
    bus.num1  = 32'd9;
    bus.num2  = 32'd3;
    #1;
    chk("flush idle div stall", {63'd0, bus.stall}, 64'd0);
    bus.op   = OP_MTHI;
    bus.num1 = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("flush idle mthi hi", 64'(bus.hi), 64'(m_hi));
    chk("flush idle stall", {63'd0, bus.stall}, 64'd0);
    tick();

    // Flush at DIV cycle 10
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.num1  = 32'd1000;
    bus.num2  = 32'd3;
    tick();
    for (int c = 1; c < 10; c++) tick();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush div stall", {63'd0, bus.stall}, 64'd0);
    chk("flush div done", {63'd0, bus.done}, 64'd0);
    chk("flush div hi", 64'(bus.hi), 64'(m_hi));
    chk("flush div lo", 64'(bus.lo), 64'(m_lo));
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 40; c++) begin
        if (bus.done || bus.stall) seen_done++;
        tick();
      end
      chk("flush div quiet", 64'(seen_done), 64'd0);
    end
    run_op("after flush divu", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 33);

    // Reset mid-operation
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.num1  = 32'd50;
    bus.num2  = 32'd7;
    for (int c = 0; c < 5; c++) tick();
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst hi", 64'(bus.hi), 64'd0);
    chk("midrst lo", 64'(bus.lo), 64'd0);
    chk("midrst stall_done", {62'd0, bus.stall, bus.done}, 64'd0);
    tick();
    run_op("after rst mult", OP_MULT, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
